blur_scheduler: RTL
===================

Name: blur_scheduler

Overview:
Frame-level sequencer for blur_controller. It walks the blur anchor across an image in 16-column strips, row by row. For each strip it waits for the line buffer to be ready, pulses anchor_moving, and waits for blur_final. It then presents the strip's coordinates to the downstream gradient stage with a valid/ready handshake. It sits between the top-level frame control and blur_controller/line buffer.

Parameters:
IMG_WIDTH, 640, image width in pixels; must be a multiple of STRIP_W.
IMG_HEIGHT, 480, image height in rows; must be at least 1.
STRIP_W, 16, columns produced per blur_controller pass; this is also the anchor_x step.
WD_CYCLES, 64, watchdog limit in cycles; used only with WATCHDOG_EN.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  begin frame; sampled only in IDLE
abort  in  1  synchronous abort; return to IDLE from any state
buf_ready  in  1  line buffer holds the rows for the current anchor
anchor_moving  out  1  one-cycle pulse to blur_controller that launches a pass
anchor_x  out  32  current strip column origin (0, 16, 32, ...)
anchor_y  out  32  current row
blur_final  in  1  blur_controller pass complete
out_valid  out  1  strip result available downstream
out_ready  in  1  downstream accepts the strip
out_x  out  32  column of the strip being presented
out_y  out  32  row of the strip being presented
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse after the last strip is accepted
err  out  1  sticky watchdog error; constant 0 without WATCHDOG_EN

Behaviour:
- Reset (n_rst low, asynchronous): state=IDLE; all outputs 0 (anchor_x/y, out_x/y = 0; err = 0).
- States: IDLE, FETCH, ISSUE, WAIT, OUTPUT, DONE. All outputs are registered.
- IDLE: if start=1, load x=0, y=0, go to FETCH.
- FETCH: hold until buf_ready=1, then go to ISSUE.
- ISSUE: anchor_moving=1 for exactly this one cycle, then go to WAIT.
- Minimum latency: start sampled at edge k puts anchor_moving high in cycle k+2 when buf_ready is already high.
- WAIT: on blur_final=1, go to OUTPUT. blur_final seen in any other state is ignored.
- OUTPUT: out_valid=1 with out_x=x, out_y=y. Values are held stable until out_ready=1.
- Handshake in OUTPUT, normal case: x += STRIP_W, go to FETCH.
- Handshake at the last column (x == IMG_WIDTH-STRIP_W): x=0, y += 1, go to FETCH.
- Handshake at the last column and last row (y == IMG_HEIGHT-1): go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- anchor_x/anchor_y update only on a handshake; they stay constant from ISSUE through OUTPUT.
- abort=1 in any state: next state IDLE, out_valid and anchor_moving deasserted, no frame_done. abort takes priority over every transition, including the handshake in the same cycle.
- start while busy is ignored. start and abort together in IDLE: stay in IDLE.
- Reset mid-frame: immediate return to IDLE values; err is cleared.
- Counters are 32-bit unsigned. The wrap compare is against the parameter-derived constant; they never overflow for legal parameters.

Optional Feature:
Macro WATCHDOG_EN.
- Defined: a cycle counter clears on entry to WAIT and increments each cycle in WAIT. If it reaches WD_CYCLES without blur_final: err=1 (sticky until reset or next accepted start), state goes to IDLE, no frame_done.
- Undefined: no counter; WAIT waits indefinitely; err tied 0.

Decomposition:
- Package blur_pkg:
  - state enum blur_sched_state_t.
  - STRIP_W default constant.
  - 32-bit coordinate typedef coord_t.
- Sub-module strip_counter holds the x/y registers with advance and clear inputs and a last-strip/last-row flag. The FSM stays in blur_scheduler.

Test Plan:
- IMG_WIDTH=32, IMG_HEIGHT=2, buf_ready=1, blur_final 3 cycles after each anchor_moving, out_ready=1 -> out_x/out_y sequence (0,0),(16,0),(0,1),(16,1); 4 anchor_moving pulses; frame_done once; busy low afterwards.
- Hold buf_ready=0 for 5 cycles in FETCH -> anchor_moving stays low until the cycle after buf_ready rises.
- out_ready=0 for 4 cycles in OUTPUT -> out_valid, out_x, out_y stable; no new anchor_moving.
- abort asserted in WAIT and again in OUTPUT together with out_ready -> IDLE next cycle; no frame_done; a new start restarts at (0,0).
- start pulsed while busy, and blur_final pulsed in FETCH -> no effect on the strip sequence.
- WATCHDOG_EN, WD_CYCLES=8, blur_final never asserted -> err=1 and IDLE 8 cycles after entering WAIT; err cleared by the next start.

Source files
------------

// File: rtl/blur_pkg.sv
// Shared types and defaults for the blur frame scheduler and its strip counter.
package blur_pkg;

    localparam int STRIP_W_DEF = 16;

    typedef logic [31:0] coord_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT,
        S_DONE
    } blur_sched_state_t;

endpackage

// File: rtl/strip_counter.sv
// Anchor position registers: column steps by STRIP_W and wraps into the next row;
// the last-column/last-row flags tell the scheduler when the frame is complete.
module strip_counter
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int STRIP_W    = STRIP_W_DEF
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   i_clear,
    input  logic   i_advance,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_last_col,
    output logic   o_last_row
);

    localparam coord_t LAST_X = coord_t'(IMG_WIDTH - STRIP_W);
    localparam coord_t LAST_Y = coord_t'(IMG_HEIGHT - 1);
    localparam coord_t STEP_X = coord_t'(STRIP_W);

    coord_t r_x;
    coord_t r_y;

    assign o_last_col = (r_x == LAST_X);
    assign o_last_row = (r_y == LAST_Y);
    assign o_x        = r_x;
    assign o_y        = r_y;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; the reset branch is asynchronous, active-low.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            // At the final strip of the frame the position is held.
            if (!o_last_col) begin
                r_x <= r_x + STEP_X;
            end else if (!o_last_row) begin
                r_x <= '0;
                r_y <= r_y + 32'd1;
            end
        end
    end

endmodule

// File: rtl/blur_scheduler.sv
// Frame sequencer walking the blur anchor over the image strip by strip.
// Optional WATCHDOG_EN adds a WAIT-state timeout that raises a sticky err.
module blur_scheduler
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int STRIP_W    = STRIP_W_DEF,
    parameter int WD_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        abort,
    input  logic        buf_ready,
    output logic        anchor_moving,
    output logic [31:0] anchor_x,
    output logic [31:0] anchor_y,
    input  logic        blur_final,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_x,
    output logic [31:0] out_y,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);

    blur_sched_state_t r_state;
    blur_sched_state_t w_next_state;

    logic   w_clear;
    logic   w_advance;
    logic   w_wd_expire;
    logic   w_wd_trip;
    logic   w_last_col;
    logic   w_last_row;
    coord_t w_x;
    coord_t w_y;

    strip_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .STRIP_W    (STRIP_W)
    ) u_strip_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_advance  (w_advance),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    assign anchor_x = w_x;
    assign anchor_y = w_y;

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_advance    = 1'b0;
        w_wd_trip    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_clear      = 1'b1;
                end
            end
            S_FETCH: begin
                if (buf_ready) w_next_state = S_ISSUE;
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (blur_final) begin
                    w_next_state = S_OUTPUT;
                end else if (w_wd_expire) begin
                    w_next_state = S_IDLE;
                    w_wd_trip    = 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    w_advance    = 1'b1;
                    w_next_state = (w_last_col && w_last_row) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        // Abort overrides everything, including a handshake in the same cycle.
        if (abort) begin
            w_next_state = S_IDLE;
            w_clear      = 1'b0;
            w_advance    = 1'b0;
            w_wd_trip    = 1'b0;
        end
    end

    // NOTE: outputs are registered from the next-state decode, so each one is
    // glitch-free yet lines up with the state it belongs to.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            anchor_moving <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            out_x         <= '0;
            out_y         <= '0;
        end else begin
            r_state       <= w_next_state;
            anchor_moving <= (w_next_state == S_ISSUE);
            out_valid     <= (w_next_state == S_OUTPUT);
            busy          <= (w_next_state != S_IDLE);
            frame_done    <= (w_next_state == S_DONE);
            if (w_next_state == S_OUTPUT && r_state != S_OUTPUT) begin
                out_x <= w_x;
                out_y <= w_y;
            end
        end
    end

`ifdef WATCHDOG_EN
    logic [31:0] r_wd_cnt;
    logic        r_err;

    assign w_wd_expire = (r_wd_cnt == 32'(WD_CYCLES - 1));
    assign err         = r_err;

    // WAIT is only ever entered from ISSUE, so ISSUE is where the count restarts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wd_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 32'd1;
            end
            if (w_wd_trip) begin
                r_err <= 1'b1;
            end else if (r_state == S_IDLE && start && !abort) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    assign w_wd_expire = 1'b0;
    assign err         = 1'b0;
`endif

endmodule
